// File: rtl/serial_ram_writer.sv
// Packs received UART bytes MSB-first into RAM words and writes them linearly
// into the frame RAM, wrapping after the last word and flagging each finished frame.
module serial_ram_writer #(
  parameter  int RAM_WIDTH      = 32,
  parameter  int N_BITS         = 307200,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int BYTES_PER_WORD = RAM_WIDTH / 8,
  localparam int RAM_DEPTH      = N_BITS / RAM_WIDTH,
  localparam int ADDR_BITS      = $clog2(RAM_DEPTH),
  localparam int MAX_ADDR       = RAM_DEPTH - 1,
  localparam int CNT_BITS       = $clog2(BYTES_PER_WORD) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  input  logic                 clear,
  output logic                 we,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0] wr_data,
  output logic                 frame_done,
  output logic [CNT_BITS-1:0]  byte_cnt,
  output logic [1:0]           state_dbg
);

  // Handshake: rx_ready is a one-cycle strobe qualifying rx_data; there is no
  // backpressure in either direction, and we is a one-cycle write that the RAM
  // always accepts, with wr_addr/wr_data held stable while it is high.

  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state;
  logic [RAM_WIDTH-1:0]  word_q;
  logic [TMO_BITS-1:0]   tmo;

  logic [CNT_BITS-1:0]   slot;
  logic [CNT_BITS-1:0]   cnt_next;
  logic [RAM_WIDTH-1:0]  word_ins;
  logic [ADDR_BITS-1:0]  addr_inc;
  logic [ADDR_BITS-1:0]  next_wr_addr;

  assign state_dbg = state;

  // A byte landing in WRITE starts a new word, so it always takes slot 0 there.
  always_comb begin
    slot         = (state == FILL) ? byte_cnt : '0;
    cnt_next     = slot + 1'b1;
    word_ins     = word_q;
    word_ins[RAM_WIDTH - 8 - 8 * int'(slot) +: 8] = rx_data;
    addr_inc     = (wr_addr == ADDR_BITS'(MAX_ADDR)) ? '0 : wr_addr + 1'b1;
    next_wr_addr = (state == WRITE) ? addr_inc : wr_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= '0;
      tmo        <= '0;
      we         <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (state == WRITE) wr_addr <= addr_inc;

      if (clear) begin
        state    <= IDLE;
        byte_cnt <= '0;
        wr_addr  <= '0;
        tmo      <= '0;
      end else if (rx_ready) begin
        word_q <= word_ins;
        tmo    <= '0;
        if (cnt_next == CNT_BITS'(BYTES_PER_WORD)) begin
          state      <= WRITE;
          byte_cnt   <= cnt_next;
          we         <= 1'b1;
          wr_data    <= word_ins;
          frame_done <= (next_wr_addr == ADDR_BITS'(MAX_ADDR));
        end else begin
          state    <= FILL;
          byte_cnt <= cnt_next;
        end
      end else begin
        case (state)
          FILL: begin
            // Stale partial word: abandon it without touching the address.
            if (tmo == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
              state    <= IDLE;
              byte_cnt <= '0;
              tmo      <= '0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          WRITE: begin
            state    <= IDLE;
            byte_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_ram_writer.sv
// Bench for serial_ram_writer: directed and random byte streams, a byte-queue
// reference model, and a monitor that checks every RAM write against it.
module tb_serial_ram_writer;

  localparam int RAM_WIDTH = 16;
  localparam int N_BITS    = 64;
  localparam int TMO       = 8;
  localparam int BPW       = RAM_WIDTH / 8;
  localparam int DEPTH     = N_BITS / RAM_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(BPW) + 1;
  localparam int W         = 32 + 1 + AW + RAM_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           rx_data = '0;
  logic                 rx_ready = 1'b0;
  logic                 clear = 1'b0;
  logic                 we;
  logic [AW-1:0]        wr_addr;
  logic [RAM_WIDTH-1:0] wr_data;
  logic                 frame_done;
  logic [CW-1:0]        byte_cnt;
  logic [1:0]           state_dbg;

  serial_ram_writer #(.RAM_WIDTH(RAM_WIDTH), .N_BITS(N_BITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .clear(clear),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .byte_cnt(byte_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  // reference model: bytes collected per word, current frame address
  logic [W-1:0] exp_q[$];
  logic [7:0]   part[$];
  int           m_addr = 0;
  int           last_e = 0;

  function automatic void model_step(bit v, logic [7:0] d, bit c, int e);
    logic [RAM_WIDTH-1:0] word;
    if (c) begin
      part.delete();
      m_addr = 0;
    end else if (v) begin
      if (part.size() > 0 && (e - last_e) > TMO) part.delete();
      part.push_back(d);
      last_e = e;
      if (part.size() == BPW) begin
        word = '0;
        foreach (part[i]) word = (word << 8) | RAM_WIDTH'(part[i]);
        exp_q.push_back({32'(e), (m_addr == DEPTH - 1), AW'(m_addr), word});
        m_addr = (m_addr + 1) % DEPTH;
        part.delete();
      end
    end
  endfunction

  // driver tasks
  task automatic drive(input bit v, input logic [7:0] d, input bit c);
    rx_ready = v;
    rx_data  = d;
    clear    = c;
    model_step(v, d, c, edge_cnt + 1);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_ready = 1'b1;
    rx_data  = 8'h5A;
    part.delete();
    m_addr = 0;
    @(posedge clk);
    #1;
    check("rst_we", 32'(we), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_byte_cnt", 32'(byte_cnt), 0);
    rst      = 1'b0;
    rx_ready = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'(wr_addr), wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_edge", 32'(edge_cnt), e[W-1 -: 32]);
        check("wr_data", 32'(wr_data), 32'(e[RAM_WIDTH-1:0]));
        check("wr_addr", 32'(wr_addr), 32'(e[RAM_WIDTH +: AW]));
        check("frame_done", 32'(frame_done), 32'(e[RAM_WIDTH + AW]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // spaced bytes form one word
    send(8'hAB);
    idle(4);
    send(8'hCD);
    check("write_byte_cnt", 32'(byte_cnt), BPW);
    idle(1);
    check("post_write_byte_cnt", 32'(byte_cnt), 0);
    idle(2);

    // consecutive bytes fill the whole frame and wrap
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 10; i++) send(8'(i));
    idle(3);

    // byte arriving on the write cycle starts the next word
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    idle(3);

    // timeout drops the lone byte at exactly TMO idle cycles
    send(8'h55);
    check("tmo_cnt_after_byte", 32'(byte_cnt), 1);
    idle(TMO - 1);
    check("tmo_cnt_before_expiry", 32'(byte_cnt), 1);
    idle(1);
    check("tmo_cnt_after_expiry", 32'(byte_cnt), 0);
    idle(2);
    send(8'h66);
    send(8'h77);
    idle(3);

    // clear mid-frame with a simultaneous byte
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i));
    send(8'h99);
    drive(1'b1, 8'hEE, 1'b1);
    check("clear_byte_cnt", 32'(byte_cnt), 0);
    check("clear_wr_addr", 32'(wr_addr), 0);
    send(8'h12);
    send(8'h34);
    idle(3);

    // reset mid-word
    send(8'h5C);
    do_reset();
    send(8'hAA);
    send(8'hBB);
    idle(3);

    // random traffic, including gaps around the timeout and clears
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) drive(1'b0, 8'h00, 1'b1);
      else if (r < 12) drive(1'b1, 8'($urandom), 1'b1);
      else if (r < 65) send(8'($urandom));
      else if (r < 72) idle($urandom_range(TMO - 1, TMO + 2));
      else idle(1);
    end
    idle(4);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_ram_writer.md
Name: serial_ram_writer

Overview:
- Upstream stage of the VGA serial display: packs bytes from the UART receiver into RAM words and writes them sequentially into the frame RAM.
- The RAM read stage later scans the same frame RAM for display.
- Fills the frame RAM linearly, wraps after the last word, and flags each completed frame.

Parameters:
- RAM_WIDTH, 32, bits per RAM word; must be a multiple of 8.
- N_BITS, 307200, total frame bits stored; must be a multiple of RAM_WIDTH.
- TIMEOUT_CYCLES, 100000, idle clk cycles after which a partially filled word is discarded.
- Derived, not overridable:
  - BYTES_PER_WORD = RAM_WIDTH/8
  - RAM_DEPTH = N_BITS/RAM_WIDTH
  - ADDR_BITS = $clog2(RAM_DEPTH)
  - MAX_ADDR = RAM_DEPTH-1

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; valid only while rx_ready=1.
- rx_ready  input  1  one-cycle strobe; rx_data is valid.
- clear  input  1  synchronous restart: drop partial word, address back to 0.
- we  output  1  RAM write enable; one-cycle pulse.
- wr_addr  output  ADDR_BITS  RAM write address.
- wr_data  output  RAM_WIDTH  RAM write data.
- frame_done  output  1  one-cycle pulse on the write of address MAX_ADDR.
- byte_cnt  output  $clog2(BYTES_PER_WORD)+1  bytes held in the current partial word.

Behaviour:
- Reset values (rst=1 at a clk edge): we=0, wr_addr=0, wr_data=0, frame_done=0, byte_cnt=0, timeout counter=0, state=IDLE.
- Reset mid-word drops the partial word; no write is issued.
- Byte ordering is MSB first:
  - First byte of a word goes to bits [RAM_WIDTH-1 -: 8], the next to the following lower byte, and so on.
  - The last byte goes to bits [7:0].
- States:
  - IDLE: no partial word.
    - rx_ready → store byte, byte_cnt=1, go to FILL.
    - If BYTES_PER_WORD=1, go directly to WRITE.
  - FILL: partial word held.
    - rx_ready → store byte, byte_cnt+1.
    - When byte_cnt reaches BYTES_PER_WORD, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - we=1, wr_data = assembled word, wr_addr = current address.
    - Next cycle: we=0 and the address increments. MAX_ADDR wraps to 0.
    - frame_done=1 in the same cycle as we when wr_addr=MAX_ADDR.
    - byte_cnt reads BYTES_PER_WORD during WRITE.
    - Then go to IDLE, or to FILL if a byte arrives during WRITE.
- Latency: we asserts the cycle after the rx_ready that delivers the word's last byte.
- Registered outputs: we, wr_addr, wr_data, frame_done are all registered; wr_data and wr_addr stay stable while we=1.
- Byte arriving during WRITE (back-to-back):
  - It is accepted and becomes byte 0 of the next word.
  - The write in progress is unaffected; next state is FILL with byte_cnt=1.
- Timeout:
  - The counter runs only in FILL and resets on every rx_ready.
  - On reaching TIMEOUT_CYCLES-1: drop the partial word, byte_cnt=0, go to IDLE.
  - The address does not change and no write is issued.
- clear:
  - Takes priority over rx_ready in the same cycle; that byte is dropped.
  - Next cycle: state=IDLE, byte_cnt=0, address=0, timeout=0.
  - If asserted during WRITE, the write still completes this cycle.
  - The address is then forced to 0, not incremented.
- rx_ready with rst=1 is ignored.
- No backpressure: the RAM accepts a write every cycle. Upstream byte rate is far below clk, but the block must tolerate rx_ready on consecutive cycles.

Test Plan (RAM_WIDTH=16, N_BITS=64 → depth 4, 2 bytes/word; TIMEOUT_CYCLES=8):
- Bytes 0xAB then 0xCD, spaced 5 cycles → one cycle after the 0xCD strobe: we=1, wr_addr=0, wr_data=0xABCD, frame_done=0; byte_cnt returns to 0.
- 8 bytes 0x01..0x08 on consecutive cycles → four writes:
  - 0x0102@0, 0x0304@1, 0x0506@2, 0x0708@3.
  - frame_done=1 only with the addr-3 write.
  - Next two bytes 0x09, 0x0A write 0x090A@0 (wrap).
- Byte arriving in the WRITE cycle: 0x11, 0x22, then 0x33 on the we cycle, then 0x44 → writes 0x1122@0 then 0x3344@1; no byte lost.
- Timeout: byte 0x55, then idle 10 cycles, then 0x66, 0x77 → no write for 0x55; byte_cnt drops to 0 within 8 cycles; write 0x6677@0.
- clear mid-frame: write 2 words (addr now 2), send 0x99, assert clear with a simultaneous byte 0xEE → partial and 0xEE dropped; next bytes 0x12, 0x34 write 0x1234@0.
- rst mid-word after one byte → all outputs 0; subsequent 0xAA, 0xBB write 0xAABB@0.
